// File: rtl/lcd_rx.sv
// HD44780-compatible display-side receiver: samples the parallel LCD write bus,
// rebuilds bytes from nibbles, executes the instruction subset and holds a DDRAM image.
module lcd_rx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              rs,
    input  logic [3:0]        data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              byte_valid,
    output logic [7:0]        byte_out,
    output logic              byte_rs,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              mode_4bit,
    output logic [2:0]        disp_ctrl,
    output logic              incr,
    output logic              proto_err
);

    typedef enum logic {PH_HIGH, PH_LOW} phase_t;

    logic              en_s1_q, en_s2_q, rs_s1_q, rs_s2_q;
    logic [3:0]        data_s1_q, data_s2_q;
    logic              fall_q, rs_f_q;
    logic [3:0]        data_f_q;

    phase_t            phase_q, phase_d;
    logic [3:0]        hi_q, hi_d;
    logic              hi_rs_q, hi_rs_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] ac_q, ac_d;
    logic [2:0]        disp_q, disp_d;
    logic              incr_q, incr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_rs_q, byte_rs_d;
    logic              byte_valid_q, byte_valid_d;
    logic              perr_q, perr_d;

    logic              done, crs, wr_en;
    logic [7:0]        cbyte;
    logic [7:0]        mem [DEPTH];

    // Synchronisers, then a registered fall strobe carrying the bus values seen while en was high
    always_ff @(posedge clk) begin
        if (reset) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            rs_s1_q   <= 1'b0;
            rs_s2_q   <= 1'b0;
            data_s1_q <= 4'h0;
            data_s2_q <= 4'h0;
            fall_q    <= 1'b0;
            rs_f_q    <= 1'b0;
            data_f_q  <= 4'h0;
        end else begin
            en_s1_q   <= en;
            en_s2_q   <= en_s1_q;
            rs_s1_q   <= rs;
            rs_s2_q   <= rs_s1_q;
            data_s1_q <= data;
            data_s2_q <= data_s1_q;
            fall_q    <= en_s2_q & ~en_s1_q;
            rs_f_q    <= rs_s2_q;
            data_f_q  <= data_s2_q;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        hi_d         = hi_q;
        hi_rs_d      = hi_rs_q;
        mode_d       = mode_q;
        ac_d         = ac_q;
        disp_d       = disp_q;
        incr_d       = incr_q;
        valid_d      = valid_q;
        byte_out_d   = byte_out_q;
        byte_rs_d    = byte_rs_q;
        byte_valid_d = 1'b0;
        perr_d       = perr_q;
        done         = 1'b0;
        crs          = 1'b0;
        cbyte        = 8'h00;
        wr_en        = 1'b0;

        if (fall_q) begin
            if (!mode_q) begin
                cbyte = {data_f_q, 4'h0};
                crs   = rs_f_q;
                done  = 1'b1;
            end else if (phase_q == PH_HIGH) begin
                hi_d    = data_f_q;
                hi_rs_d = rs_f_q;
                phase_d = PH_LOW;
            end else begin
                // The high nibble's rs governs the byte; a disagreeing low nibble is flagged
                cbyte   = {hi_q, data_f_q};
                crs     = hi_rs_q;
                done    = 1'b1;
                phase_d = PH_HIGH;
                if (rs_f_q != hi_rs_q) perr_d = 1'b1;
            end
        end

        if (done) begin
            byte_valid_d = 1'b1;
            byte_out_d   = cbyte;
            byte_rs_d    = crs;
            if (crs) begin
                wr_en          = 1'b1;
                valid_d[ac_q]  = 1'b1;
                ac_d           = incr_q ? ac_q + ADDR_W'(1) : ac_q - ADDR_W'(1);
            end else if (cbyte[7]) begin
                ac_d = cbyte[ADDR_W-1:0];
            end else if (cbyte[6]) begin
                perr_d = 1'b1;
            end else if (cbyte[5]) begin
                mode_d = ~cbyte[4];
                if (!cbyte[4]) phase_d = PH_HIGH;
            end else if (cbyte[4]) begin
                if (!cbyte[3]) ac_d = cbyte[2] ? ac_q + ADDR_W'(1) : ac_q - ADDR_W'(1);
            end else if (cbyte[3]) begin
                disp_d = cbyte[2:0];
            end else if (cbyte[2]) begin
                incr_d = cbyte[1];
            end else if (cbyte[1]) begin
                ac_d = '0;
            end else if (cbyte[0]) begin
                valid_d = '0;
                ac_d    = '0;
                incr_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= PH_HIGH;
            mode_q       <= 1'b0;
            ac_q         <= '0;
            disp_q       <= 3'b000;
            incr_q       <= 1'b1;
            valid_q      <= '0;
            byte_out_q   <= 8'h00;
            byte_rs_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            mode_q       <= mode_d;
            ac_q         <= ac_d;
            disp_q       <= disp_d;
            incr_q       <= incr_d;
            valid_q      <= valid_d;
            byte_out_q   <= byte_out_d;
            byte_rs_q    <= byte_rs_d;
            byte_valid_q <= byte_valid_d;
            perr_q       <= perr_d;
        end
    end

    // Character storage and the held high nibble need no reset; valid bits and phase mask them
    always_ff @(posedge clk) begin
        hi_q    <= hi_d;
        hi_rs_q <= hi_rs_d;
        if (wr_en && !reset) mem[ac_q] <= cbyte;
    end

    assign rd_data    = valid_q[rd_addr] ? mem[rd_addr] : 8'h20;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_rs    = byte_rs_q;
    assign cur_addr   = ac_q;
    assign mode_4bit  = mode_q;
    assign disp_ctrl  = disp_q;
    assign incr       = incr_q;
    assign proto_err  = perr_q;

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: drives LCD bus strobes and checks state with immediate assertions.
module tb_lcd_rx;

    logic       clk = 1'b0;
    logic       reset, en, rs;
    logic [3:0] data, rd_addr;
    logic [7:0] rd_data, byte_out;
    logic       byte_valid, byte_rs, mode_4bit, incr, proto_err;
    logic [3:0] cur_addr;
    logic [2:0] disp_ctrl;

    int tests = 0;
    int fails = 0;
    int pcnt  = 0;
    logic bv_n3;

    lcd_rx #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .rs(rs), .data(data),
        .rd_addr(rd_addr), .rd_data(rd_data), .byte_valid(byte_valid),
        .byte_out(byte_out), .byte_rs(byte_rs), .cur_addr(cur_addr),
        .mode_4bit(mode_4bit), .disp_ctrl(disp_ctrl), .incr(incr),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (byte_valid) pcnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk($sformatf("rd_data[%0d]", a), {24'h0, rd_data}, {24'h0, exp});
    endtask

    // 3 cycles high, 3 low; bv_n3 samples byte_valid in the cycle after E2
    task automatic nib(input logic r, input logic [3:0] n);
        @(negedge clk);
        rs = r; data = n; en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        bv_n3 = byte_valid;
    endtask

    task automatic byte4(input logic r, input logic [7:0] b);
        nib(r, b[7:4]);
        nib(r, b[3:0]);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, " mode_4bit"}, {31'h0, mode_4bit}, 32'h0);
        chk({pfx, " cur_addr"}, {28'h0, cur_addr}, 32'h0);
        chk({pfx, " disp_ctrl"}, {29'h0, disp_ctrl}, 32'h0);
        chk({pfx, " incr"}, {31'h0, incr}, 32'h1);
        chk({pfx, " proto_err"}, {31'h0, proto_err}, 32'h0);
        chk({pfx, " byte_out"}, {24'h0, byte_out}, 32'h0);
        chk({pfx, " byte_rs"}, {31'h0, byte_rs}, 32'h0);
        chk({pfx, " byte_valid"}, {31'h0, byte_valid}, 32'h0);
        chk_rd(4'd0, 8'h20);
    endtask

    initial begin
        logic [7:0] clk_str [5];
        clk_str = '{8'h20, 8'h39, 8'h3A, 8'h30, 8'h35};
        reset = 1'b1; en = 1'b0; rs = 1'b0; data = 4'h0; rd_addr = 4'h0; bv_n3 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // Standard init sequence
        nib(1'b0, 4'h3);
        chk("8bit after 0x30", {31'h0, mode_4bit}, 32'h0);
        nib(1'b0, 4'h3);
        nib(1'b0, 4'h3);
        nib(1'b0, 4'h2);
        chk("byte_valid latency", {31'h0, bv_n3}, 32'h1);
        chk("byte_out 0x20", {24'h0, byte_out}, 32'h20);
        chk("4bit after 0x20", {31'h0, mode_4bit}, 32'h1);
        byte4(1'b0, 8'h28);
        byte4(1'b0, 8'h0C);
        byte4(1'b0, 8'h06);
        byte4(1'b0, 8'h01);
        chk("init mode_4bit", {31'h0, mode_4bit}, 32'h1);
        chk("init disp_ctrl", {29'h0, disp_ctrl}, 32'h4);
        chk("init incr", {31'h0, incr}, 32'h1);
        chk("init cur_addr", {28'h0, cur_addr}, 32'h0);
        chk("init proto_err", {31'h0, proto_err}, 32'h0);
        for (int i = 0; i < 16; i++) chk_rd(4'(i), 8'h20);

        // Clock string
        pcnt = 0;
        byte4(1'b0, 8'h80);
        for (int i = 0; i < 5; i++) byte4(1'b1, clk_str[i]);
        for (int i = 0; i < 5; i++) chk_rd(4'(i), clk_str[i]);
        chk("clock cur_addr", {28'h0, cur_addr}, 32'h5);
        chk("clock pulses", pcnt, 32'd6);
        chk("clock byte_rs", {31'h0, byte_rs}, 32'h1);

        // Cursor shift right then left
        byte4(1'b0, 8'h14);
        chk("shift right", {28'h0, cur_addr}, 32'h6);
        byte4(1'b0, 8'h10);
        chk("shift left", {28'h0, cur_addr}, 32'h5);

        // Wrap and decrement
        byte4(1'b0, 8'h8F);
        byte4(1'b1, 8'h41);
        chk("wrap cur_addr", {28'h0, cur_addr}, 32'h0);
        chk_rd(4'd15, 8'h41);
        byte4(1'b0, 8'h04);
        chk("entry incr=0", {31'h0, incr}, 32'h0);
        byte4(1'b1, 8'h42);
        chk_rd(4'd0, 8'h42);
        chk("dec cur_addr", {28'h0, cur_addr}, 32'hF);

        // Mismatched rs between nibbles
        chk("pre-mismatch proto_err", {31'h0, proto_err}, 32'h0);
        nib(1'b1, 4'h4);
        nib(1'b0, 4'h8);
        chk("mismatch proto_err", {31'h0, proto_err}, 32'h1);
        chk("mismatch byte_rs", {31'h0, byte_rs}, 32'h1);
        chk("mismatch byte_out", {24'h0, byte_out}, 32'h48);
        chk_rd(4'd15, 8'h48);
        chk("mismatch cur_addr", {28'h0, cur_addr}, 32'hE);
        byte4(1'b0, 8'h40);
        chk("cgram proto_err", {31'h0, proto_err}, 32'h1);

        // Reset mid-byte
        nib(1'b0, 4'h4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        nib(1'b0, 4'h2);
        chk("post-rst 4bit", {31'h0, mode_4bit}, 32'h1);

        // Clear after filling every address
        for (int i = 0; i < 16; i++) byte4(1'b1, 8'h55);
        chk_rd(4'd7, 8'h55);
        chk("fill cur_addr", {28'h0, cur_addr}, 32'h0);
        byte4(1'b0, 8'h04);
        byte4(1'b0, 8'h01);
        for (int i = 0; i < 16; i++) chk_rd(4'(i), 8'h20);
        chk("clear cur_addr", {28'h0, cur_addr}, 32'h0);
        chk("clear incr", {31'h0, incr}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_rx.md
# lcd_rx

HD44780-compatible display-side receiver: the far end of the 4/8-bit parallel LCD write bus (`en`, `rs`, `data[3:0]`). It samples the bus, rebuilds bytes from nibbles, executes the HD44780 instruction subset and holds a character buffer (DDRAM) that a read port exposes. It is used on-chip as a mock display and as a bus checker for the LCD driver.

## Interface
- `DEPTH`, 16: DDRAM size in characters; must be a power of two.
- `ADDR_W`, 4: address width, equal to log2(DEPTH).
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `en` in 1: LCD enable strobe; latched on its falling edge.
- `rs` in 1: register select (0 = instruction, 1 = data).
- `data` in 4: bus lines DB7..DB4.
- `rd_addr` in ADDR_W: DDRAM read address.
- `rd_data` out 8: character at `rd_addr`, combinational; returns 0x20 if the entry is cleared.
- `byte_valid` out 1: one-cycle pulse when a byte completes.
- `byte_out` out 8: last completed byte, held until the next one.
- `byte_rs` out 1: `rs` value of the last completed byte.
- `cur_addr` out ADDR_W: address counter (AC).
- `mode_4bit` out 1: 1 when the bus is in 4-bit mode.
- `disp_ctrl` out 3: {D, C, B} from display control.
- `incr` out 1: entry-mode I/D bit.
- `proto_err` out 1: sticky protocol error flag.

## Operation
- Input stage: `en`, `rs` and `data` each pass through 2-flop synchronisers (s1, s2). A fall is detected when s2=1 and s1=0. The `rs` and `data` values are taken from stage s2 at that point, so they are the values present while `en` was high.
- 8-bit mode (after reset): each fall forms byte = {data, 4'h0}.
  - Function set with DL=0 (byte 0x20–0x2F, which includes nibble 0x2) switches to 4-bit mode and sets the phase to HIGH.
  - Nibble 0x3 is function set with DL=1: no mode change.
- 4-bit mode: phase HIGH stores the nibble and `rs`, then goes to LOW. Phase LOW forms byte = {hi, data}, then goes back to HIGH.
  - If `rs` differs between the two nibbles: set `proto_err`; the high nibble's `rs` is used.
- Instruction execution on byte completion with rs=0, decoded by priority on the top set bit:
  - 0x01 clear: all valid bits = 0, AC = 0, `incr` = 1. Takes one cycle; no busy period.
  - 0x02/0x03 home: AC = 0.
  - 0x04–0x07 entry mode: `incr` = bit1; S bit ignored.
  - 0x08–0x0F display control: `disp_ctrl` = bits[2:0].
  - 0x10–0x1F cursor/shift: if bit3=0, AC ±1 (bit2=1 means +1); display shift is ignored.
  - 0x20–0x3F function set: `mode_4bit` = ~bit4. On entry to 4-bit mode the phase is HIGH. N and F are ignored.
  - 0x40–0x7F CGRAM address: not supported; set `proto_err`.
  - 0x80–0xFF: AC = byte[ADDR_W-1:0] (upper bits dropped).
- Data execution (rs=1): DDRAM[AC] = byte, valid[AC] = 1, then AC = AC+1 if `incr`, otherwise AC−1. Wraps modulo DEPTH.
- `proto_err` clears only on reset.

## Timing
- Latency: let E0 be the first clk edge that samples `en`=0. Input flops update at E0 and E1. The fall is seen between E1 and E2. At E2 the byte/nibble is accepted, and state, DDRAM, AC and the `byte_*` outputs update. `byte_valid` is high for the cycle after E2.
- Minimum strobe: `en` high for ≥2 clk cycles and low for ≥2 cycles. Shorter pulses may be missed and are not flagged.
- A rising `en` has no effect.
- `rd_data` reflects a DDRAM write in the cycle after E2.
- Reset values:
  - Outputs and control: `mode_4bit`=0, phase HIGH, AC=0, `disp_ctrl`=000, `incr`=1, all valid bits 0, `byte_out`=0x00, `byte_rs`=0, `byte_valid`=0, `proto_err`=0, synchronisers=0.
  - DDRAM contents are don't-care, masked by the valid bits.
- Reset mid-byte: a stored high nibble is discarded and the block returns to 8-bit mode.
- A fall during reset is ignored.

## Test plan
- Standard init: nibbles 3,3,3,2 then bytes 0x28, 0x0C, 0x06, 0x01 in 4-bit mode, strobe 3 cycles high / 3 low. Required: `mode_4bit`=1, `disp_ctrl`=100, `incr`=1, AC=0, `rd_data`=0x20 at every address, `proto_err`=0.
- Clock string: after init send 0x80 and then data " 9:05". Required: `rd_data` at addresses 0–4 = 0x20, 0x39, 0x3A, 0x30, 0x35; AC=5; exactly 6 `byte_valid` pulses.
- Wrap and decrement:
  - 0x8F, data 0x41 → AC=0, DDRAM[15]=0x41.
  - Then 0x04 (I/D=0), data 0x42 → DDRAM[0]=0x42, AC=15.
- Mismatched `rs`: high nibble with rs=1, low nibble with rs=0, byte 0x48 → `proto_err`=1, `byte_rs`=1, DDRAM[AC]=0x48. After that, 0x40 keeps `proto_err`=1.
- Reset mid-byte: in 4-bit mode send high nibble 0x4, assert reset for 1 cycle. Required: `mode_4bit`=0, all outputs at reset values. The next nibble 0x2 sets `mode_4bit`=1.
- Clear after writes: fill 16 chars with 0x55, send 0x01. Required: `rd_data`=0x20 at every address on the cycle after E2, AC=0.
